// File: rtl/matrix_buffer_seq.sv
// Port sequencer for sram_matrix_buffer_wide: loads rows from a valid/ready stream into
// consecutive buffer addresses, then drains them back out through a 2-entry skid FIFO.
module matrix_buffer_seq #(
    parameter int ARR_WIDTH  = 16,
    parameter int ADDR_DEPTH = 128,
    parameter int ADDR_W     = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start_load,
    input  logic                   start_drain,
    input  logic [ADDR_W:0]        num_rows,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [ARR_WIDTH*8-1:0] s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ARR_WIDTH*8-1:0] m_data,
    output logic                   sram_enable,
    output logic                   sram_wr_en,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [ARR_WIDTH*8-1:0] sram_wdata,
    input  logic [ARR_WIDTH*8-1:0] sram_rdata,
    output logic                   busy,
    output logic                   done
);

    localparam int DW = ARR_WIDTH * 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(ADDR_DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] n_q, n_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] out_cnt_q, out_cnt_d;
    logic            inflight_q, inflight_d;
    logic [1:0]      fifo_cnt_q, fifo_cnt_d;
    logic            fifo_wr_q, fifo_wr_d;
    logic            fifo_rd_q, fifo_rd_d;
    logic [DW-1:0]   fifo_q [2];

    logic            num_ok;
    logic            accept;
    logic            issue;
    logic            push;
    logic            pop;
    logic [2:0]      credit;

    assign num_ok  = (num_rows != '0) && (num_rows <= DEPTH_L);
    assign s_ready = (state_q == LOAD);
    assign busy    = (state_q == LOAD) || (state_q == DRAIN);
    assign done    = (state_q == DONE);
    assign m_valid = (fifo_cnt_q != 2'd0);
    assign m_data  = fifo_q[fifo_rd_q];

    assign accept  = (state_q == LOAD) && s_valid;
    assign push    = inflight_q;
    assign pop     = m_valid && m_ready;
    // A row leaving this cycle frees its slot, which keeps the read pipe full under m_ready=1.
    assign credit  = {1'b0, fifo_cnt_q} + {2'b0, inflight_q};
    assign issue   = (state_q == DRAIN) && (rd_ptr_q < n_q) && (credit < (3'd2 + {2'b0, pop}));

    assign sram_enable = !(accept || issue);
    assign sram_wr_en  = !accept;
    assign sram_addr   = accept ? wr_ptr_q[ADDR_W-1:0] :
                         issue  ? rd_ptr_q[ADDR_W-1:0] : '0;
    assign sram_wdata  = accept ? s_data : '0;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        out_cnt_d  = out_cnt_q;
        inflight_d = issue;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        fifo_wr_d  = fifo_wr_q ^ push;
        fifo_rd_d  = fifo_rd_q ^ pop;
        case (state_q)
            IDLE: begin
                if ((start_load || start_drain) && num_ok) begin
                    state_d    = start_load ? LOAD : DRAIN;
                    n_d        = num_rows;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    out_cnt_d  = '0;
                    fifo_cnt_d = 2'd0;
                    fifo_wr_d  = 1'b0;
                    fifo_rd_d  = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + ONE_L;
                    if (wr_ptr_q == n_q - ONE_L) begin
                        state_d = DONE;
                    end
                end
            end
            DRAIN: begin
                if (issue) begin
                    rd_ptr_d = rd_ptr_q + ONE_L;
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + ONE_L;
                    if (out_cnt_q == n_q - ONE_L) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            fifo_cnt_q <= 2'd0;
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    fifo_q[gi] <= '0;
                end else if (push && (fifo_wr_q == 1'(gi))) begin
                    fifo_q[gi] <= sram_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_matrix_buffer_seq.sv
// Directed bench for matrix_buffer_seq with a behavioural active-low, 1-cycle-latency buffer model.
module tb_matrix_buffer_seq;

    localparam int AW    = 16;
    localparam int DEPTH = 128;
    localparam int ADW   = 7;
    localparam int DW    = AW * 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start_load = 1'b0;
    logic           start_drain = 1'b0;
    logic [ADW:0]   num_rows = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  s_data = '0;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [DW-1:0]  m_data;
    logic           sram_enable;
    logic           sram_wr_en;
    logic [ADW-1:0] sram_addr;
    logic [DW-1:0]  sram_wdata;
    logic [DW-1:0]  sram_rdata;
    logic           busy;
    logic           done;

    logic [DW-1:0]  sram_mem [DEPTH];
    logic [DW-1:0]  exp_mem  [DEPTH];
    int             total = 0;
    int             bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_enable) begin
            if (!sram_wr_en) sram_mem[sram_addr] <= sram_wdata;
            else             sram_rdata <= sram_mem[sram_addr];
        end
    end

    matrix_buffer_seq #(.ARR_WIDTH(AW), .ADDR_DEPTH(DEPTH), .ADDR_W(ADW)) dut (
        .clk(clk), .reset_n(reset_n), .start_load(start_load), .start_drain(start_drain),
        .num_rows(num_rows), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .sram_enable(sram_enable), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_strobe"}, {sram_enable, sram_wr_en}, 2'b11);
        chk({tag, "_flags"}, {s_ready, m_valid, busy, done}, 4'b0000);
    endtask

    task automatic do_load(input int n, input bit gaps);
        int k;
        int cyc;
        @(negedge clk);
        num_rows   = 8'(n);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 600) begin
            s_valid = gaps ? (cyc % 3 != 1) : 1'b1;
            if (s_valid) s_data = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("ld_s_ready", s_ready, 1'b1);
            chk("ld_busy", busy, 1'b1);
            if (s_valid) begin
                chk("ld_strobe", {sram_enable, sram_wr_en}, 2'b00);
                chk("ld_addr", sram_addr, k);
                chk("ld_wdata", sram_wdata, s_data);
                exp_mem[k] = s_data;
                k++;
            end else begin
                chk("ld_gap_strobe", {sram_enable, sram_wr_en}, 2'b11);
            end
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        chk("ld_count", k, n);
        #1;
        chk("ld_done", {done, busy, s_ready, sram_enable, sram_wr_en}, 5'b10011);
        @(negedge clk);
        #1;
        check_idle("ld_after");
        $display("load n=%0d gaps=%0d accepted=%0d cycles=%0d", n, gaps, k, cyc);
    endtask

    task automatic do_drain(input int n, input bit stall, input int abort_at);
        int k;
        int cyc;
        int issued;
        bit prev_stall;
        bit aborted;
        logic [DW-1:0] prev_data;
        @(negedge clk);
        num_rows    = 8'(n);
        start_drain = 1'b1;
        @(negedge clk);
        start_drain = 1'b0;
        k = 0; cyc = 0; issued = 0; prev_stall = 1'b0; aborted = 1'b0;
        prev_data = '0;
        while (k < n && cyc < 2000) begin
            if (k == abort_at) begin
                #1 reset_n = 1'b0;
                #1;
                check_idle("rst_mid");
                @(negedge clk);
                #1;
                check_idle("rst_hold");
                reset_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk("dr_busy", busy, 1'b1);
            chk("dr_s_ready", s_ready, 1'b0);
            if (!sram_enable) begin
                chk("dr_rd_strobe", sram_wr_en, 1'b1);
                chk("dr_rd_addr", sram_addr, issued);
                issued++;
            end
            if (!stall) chk("dr_rate", m_valid, (cyc >= 2) ? 1'b1 : 1'b0);
            if (prev_stall) begin
                chk("dr_hold_valid", m_valid, 1'b1);
                chk("dr_hold_data", m_data, prev_data);
            end
            if (m_valid) chk("dr_data", m_data, exp_mem[k]);
            if (m_valid && m_ready) k++;
            chk("dr_outstanding", (issued - k) <= 2, 1'b1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        if (!aborted) begin
            chk("dr_count", k, n);
            chk("dr_issued", issued, n);
            #1;
            chk("dr_done", {done, busy, m_valid, sram_enable}, 4'b1001);
            @(negedge clk);
            #1;
            check_idle("dr_after");
        end
        $display("drain n=%0d stall=%0d delivered=%0d aborted=%0d cycles=%0d", n, stall, k, aborted, cyc);
    endtask

    initial begin
        #12;
        chk("rst_strobe", {sram_enable, sram_wr_en}, 2'b11);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_flags", {s_ready, m_valid, busy, done}, 4'b0000);
        @(negedge clk);
        #1 reset_n = 1'b1;

        do_load(128, 1'b0);
        do_drain(128, 1'b0, -1);
        do_drain(8, 1'b1, -1);
        do_load(5, 1'b1);

        @(negedge clk);
        num_rows = 8'd0; start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
        #1 check_idle("ign_zero");
        @(negedge clk);
        num_rows = 8'd129; start_drain = 1'b1;
        @(negedge clk);
        start_drain = 1'b0;
        #1 check_idle("ign_big");
        $display("ignored starts num_rows=0 and num_rows=129");

        do_drain(8, 1'b0, 3);
        do_drain(8, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
